// File: rtl/instr_encoder.sv
// instr_encoder
//   Streaming MIPS instruction encoder. Takes decoded field bundles over a
//   valid/ready handshake and emits 32-bit machine words, each tagged with a
//   sequential instruction-memory word address. It produces only the six
//   opcodes that the main control decoder understands: R-type, LW, SW, BEQ,
//   ADDI and J.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            one-cycle pulse that opens a new load session
//   in_valid/ready   input handshake for one field bundle
//   in_kind          0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J (6,7 illegal)
//   in_rs/rt/rd      register fields
//   in_shamt/funct   R-type shift amount and function code
//   in_imm           I-type immediate
//   in_target        J-type target
//   out_valid/ready  output handshake toward the instruction memory
//   out_addr         word address of out_data
//   out_data         encoded instruction word
//   count            words delivered this session
//   full             2^ADDR_W words accepted; input closed until start/reset
//   err              sticky flag: an illegal kind was consumed
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {EMPTY, PEND} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wptr;
  logic [ADDR_W-1:0]   addr_p1;
  logic [31:0]         data_p1;
  logic                legal_p0;
  logic                accept_p0;
  logic                take_p0;
  logic                hs_p1;
  logic [31:0]         word_p0;

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'd0;
    case (kind)
      3'd0:    w = {6'b000000, rs, rt, rd, shamt, funct};
      3'd1:    w = {6'b100011, rs, rt, imm};
      3'd2:    w = {6'b101011, rs, rt, imm};
      3'd3:    w = {6'b000100, rs, rt, imm};
      3'd4:    w = {6'b001000, rs, rt, imm};
      3'd5:    w = {6'b000010, target};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // full is simply the carry bit of the write pointer: it is set exactly
  // when 2^ADDR_W legal bundles have been accepted.
  assign full      = wptr[ADDR_W];
  assign out_valid = (state_q == PEND);
  assign out_addr  = addr_p1;
  assign out_data  = data_p1;

  // Stage p0: input handshake and encoding
  // The start cycle refuses input so a bundle can never slip into the
  // session that start is about to clear.
  assign in_ready  = !start && !full && (!out_valid || out_ready);
  assign accept_p0 = in_valid && in_ready;
  assign legal_p0  = (in_kind <= 3'd5);
  assign take_p0   = accept_p0 && legal_p0;
  assign word_p0   = encode(in_kind, in_rs, in_rt, in_rd, in_shamt,
                            in_funct, in_imm, in_target);

  // Stage p1: pending output word
  assign hs_p1 = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (take_p0) state_d = PEND;
      PEND:    if (hs_p1 && !take_p0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      wptr    <= '0;
      count   <= '0;
      err     <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (start) begin
      // Any pending word is discarded; address/data are left as they are
      // since out_valid is low.
      state_q <= EMPTY;
      wptr    <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_p0) begin
        data_p1 <= word_p0;
        addr_p1 <= wptr[ADDR_W-1:0];
        wptr    <= wptr + 1'b1;
      end
      if (hs_p1) count <= count + 1'b1;
      if (accept_p0 && !legal_p0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder. A 64-word instance carries the main directed
// sequence with a scoreboard on its output port; a 4-word instance sharing
// the same inputs is used for the fill/full behaviour.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, full, err;
  logic [5:0]  out_addr;
  logic [31:0] out_data;
  logic [6:0]  count;

  logic        rdy2, valid2, full2, err2;
  logic [1:0]  addr2;
  logic [31:0] data2;
  logic [2:0]  count2;

  int total = 0;
  int bad = 0;
  int next_addr = 0;
  bit sb_en = 1'b1;
  logic [37:0] sbq[$];
  logic [37:0] sb_e;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .count(count), .full(full), .err(err)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(rdy2), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .out_valid(valid2),
    .out_ready(out_ready), .out_addr(addr2), .out_data(data2),
    .count(count2), .full(full2), .err(err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a handshake that will happen at the coming edge is seen here.
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_e = sbq.pop_front();
        chk("out_addr", {58'd0, out_addr}, {58'd0, sb_e[37:32]});
        chk("out_data", {32'd0, out_data}, {32'd0, sb_e[31:0]});
      end
    end
  end

  task automatic set_fields(input logic [2:0] k, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic [25:0] tgt);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  // Present one bundle, wait (bounded) for in_ready, record the expected word.
  task automatic send(input logic [2:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt,
                      input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    set_fields(k, rs, rt, rd, sh, fn, imm, tgt);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    if (ok && k <= 3'd5) begin
      sbq.push_back({6'(next_addr), w});
      next_addr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    chk("in_ready_in_start", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    sbq.delete();
    next_addr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_addr", {58'd0, out_addr}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_count", {57'd0, count}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // every kind, back to back, addrs 0..5
    out_ready = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h00221820);
    send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 32'h8C080004);
    send(3'd2, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 32'hAFBF0008);
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 32'h1022FFFF);
    send(3'd4, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 32'h20020005);
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 32'h08000010);
    idle(3);
    chk("kinds_count", {57'd0, count}, 64'd6);
    chk("kinds_err", {63'd0, err}, 64'd0);

    // backpressure: word at addr 6 stalls for 3 cycles with input waiting
    out_ready = 1'b0;
    send(3'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 32'h20641234);
    set_fields(3'd1, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_addr", {58'd0, out_addr}, 64'd6);
      chk("bp_out_data", {32'd0, out_data}, 64'h20641234);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd1, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 32'h8CA60010);
    idle(3);
    chk("bp_count", {57'd0, count}, 64'd8);

    // illegal kind between two ADDIs
    pulse_start();
    send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 32'h20010001);
    send(3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hAAAA, 26'h0, 32'h0);
    send(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0, 32'h20210002);
    idle(3);
    chk("ill_err", {63'd0, err}, 64'd1);
    chk("ill_count", {57'd0, count}, 64'd2);

    // start while a word is pending
    out_ready = 1'b0;
    send(3'd4, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0, 32'h20430003);
    @(negedge clk);
    chk("pre_start_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("st_out_valid", {63'd0, out_valid}, 64'd0);
    chk("st_count", {57'd0, count}, 64'd0);
    chk("st_err", {63'd0, err}, 64'd0);
    chk("st_full", {63'd0, full}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 32'h0BFFFFFF);
    idle(3);
    chk("st_count_after", {57'd0, count}, 64'd1);

    // reset during streaming at addr 3
    pulse_start();
    send(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 32'h20010001);
    send(3'd4, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0, 32'h20020002);
    send(3'd4, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0, 32'h20030003);
    idle(1);
    out_ready = 1'b0;
    send(3'd4, 5'd0, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 32'h20040004);
    @(negedge clk);
    chk("pre_rst_addr", {58'd0, out_addr}, 64'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    next_addr = 0;
    @(negedge clk);
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_out_addr", {58'd0, out_addr}, 64'd0);
    chk("mrst_out_data", {32'd0, out_data}, 64'd0);
    chk("mrst_count", {57'd0, count}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0000, 26'h0, 32'hAC220000);
    idle(3);
    chk("mrst_count_after", {57'd0, count}, 64'd1);
    chk("sb_drained", {32'd0, 32'(sbq.size())}, 64'd0);

    // fill the 4-word instance
    sb_en = 1'b0;
    pulse_start();
    out_ready = 1'b1;
    set_fields(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0009, 26'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fill_in_ready", {63'd0, rdy2}, 64'd1);
      chk("fill_full_low", {63'd0, full2}, 64'd0);
      if (i > 0) chk("fill_addr", {62'd0, addr2}, 64'(i - 1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("fill_full", {63'd0, full2}, 64'd1);
    chk("fill_in_ready_5th", {63'd0, rdy2}, 64'd0);
    chk("fill_last_addr", {62'd0, addr2}, 64'd3);
    chk("fill_last_data", {32'd0, data2}, 64'h20010009);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill_count", {61'd0, count2}, 64'd4);
    chk("fill_drained", {63'd0, valid2}, 64'd0);
    chk("fill_still_full", {63'd0, full2}, 64'd1);
    chk("fill_err", {63'd0, err2}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
